alu_serial: RTL
===============

// Module: alu_serial
// PURPOSE
//   Multi-cycle, slice-serial integer ALU that executes the 3-bit ALUControl
//   encoding produced by the ALU decoder (ADD/SUB/AND/OR/SLT).
//   It processes operands SLICE bits per cycle with a carry held between cycles.
//   A valid/ready handshake connects it to the issue stage and to the writeback stage.
//   It is the area-reduced execute unit for the low-cost core variant.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   SLICE  8   bits processed per cycle; WIDTH % SLICE == 0 required; NSLICE = WIDTH/SLICE
// PORTS
//   clk          in   1      clock; all state updates on rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   in_valid     in   1      operation request valid
//   in_ready     out  1      unit idle and able to accept a request
//   alu_control  in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT; others illegal
//   src_a        in   WIDTH  operand A
//   src_b        in   WIDTH  operand B
//   out_valid    out  1      result valid
//   out_ready    in   1      consumer accepts the result
//   result       out  WIDTH  operation result
//   zero         out  1      result == 0
//   illegal      out  1      the completed operation had an unsupported alu_control code
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, result=0, zero=0,
//     illegal=0, slice counter=0, carry=0. Reset mid-operation aborts it; no result is produced.
//   - FSM has three states: IDLE, BUSY and DONE.
//     IDLE:  in_ready=1. When in_valid=1 at an edge, latch src_a, src_b and alu_control.
//            Set carry=1 for SUB/SLT and 0 otherwise. Set cnt=0, clear result, go to BUSY.
//     BUSY:  in_ready=0, out_valid=0. Each edge processes slice cnt (bits cnt*SLICE +: SLICE):
//            ADD: a+b+carry. SUB/SLT: a+~b+carry. AND: a&b. OR: a|b.
//            Write the slice into the result register and update carry from the slice carry-out.
//            cnt increments. After the edge processing slice NSLICE-1, go to DONE.
//     DONE:  out_valid=1. result, zero and illegal are held stable while out_ready=0.
//            When out_ready=1 at an edge, go to IDLE. A new request is not accepted in the same edge.
//   - Latency: out_valid rises exactly NSLICE edges after the accepting edge.
//     Throughput is one operation per NSLICE+2 cycles when out_ready is held at 1.
//   - SLT: on the final slice, compute ov = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]).
//     The final result is {WIDTH-1 zeros, diff[W-1]^ov}; the partial slices are discarded.
//   - Illegal codes (100, 110, 111): same latency and flow, result=0, illegal=1.
//     illegal=0 for every legal code.
//   - zero is registered together with the final result on entry to DONE.
//   - Inputs are sampled only at the accepting edge; changes during BUSY/DONE are ignored.
//   - Carry out of the MSB is discarded; arithmetic wraps modulo 2^WIDTH.
//   - in_valid while not IDLE is ignored. The requester must hold it until in_ready.
// TESTING (WIDTH=32, SLICE=8)
//   - ADD 0x000000FF + 0x00000001 -> result 0x00000100 (carry crosses a slice), zero=0,
//     out_valid exactly 4 edges after accept.
//   - SUB 0x00000005 - 0x00000005 -> result 0, zero=1.
//     SUB 0 - 1 -> 0xFFFFFFFF (wrap).
//   - SLT 0x80000000 vs 0x00000001 -> result 1 (overflow path).
//     SLT 0x7FFFFFFF vs 0xFFFFFFFF -> result 0.
//   - AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000.
//     OR of the same operands -> 0xFFF0FFF0.
//   - out_ready held 0 for 3 cycles in DONE -> result/out_valid stable, in_ready=0.
//     Then out_ready=1 -> IDLE next edge.
//   - alu_control=3'b111 -> result 0, illegal=1, zero=1.
//     rst_n pulsed low mid-BUSY -> out_valid=0, in_ready=1, result=0 immediately.

Source files
------------

// File: rtl/alu_serial.sv
// Slice-serial ALU: ADD/SUB/AND/OR/SLT processed SLICE bits per cycle with a
// carry held between cycles; valid/ready handshake on both sides.
module alu_serial #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b101;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, result_q;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, in_ready_q, out_valid_q, zero_q, illegal_q;

   logic [SLICE-1:0] a_s, b_s, b_eff, slice_r;
   logic [SLICE:0]   sum;
   logic [WIDTH-1:0] result_d, final_d;
   logic             sub, last, ov, legal;

   always_comb begin
      a_s = '0;
      b_s = '0;
      for (int unsigned i = 0; i < NSLICE; i++) begin
         if (cnt_q == CW'(i)) begin
            a_s = a_q[i*SLICE +: SLICE];
            b_s = b_q[i*SLICE +: SLICE];
         end
      end
      sub   = (op_q == OP_SUB) || (op_q == OP_SLT);
      b_eff = sub ? ~b_s : b_s;
      sum   = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
      legal = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND) ||
              (op_q == OP_OR)  || (op_q == OP_SLT);

      case (op_q)
         OP_ADD, OP_SUB, OP_SLT: slice_r = sum[SLICE-1:0];
         OP_AND:                 slice_r = a_s & b_s;
         OP_OR:                  slice_r = a_s | b_s;
         default:                slice_r = '0;
      endcase

      result_d = result_q;
      for (int unsigned i = 0; i < NSLICE; i++) begin
         if (cnt_q == CW'(i)) result_d[i*SLICE +: SLICE] = slice_r;
      end

      last = (cnt_q == CW'(NSLICE - 1));
      // On the final slice, sum[SLICE-1] is the MSB of the full difference.
      ov   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[SLICE-1] != a_q[WIDTH-1]);

      if (!legal)                final_d = '0;
      else if (op_q == OP_SLT)   final_d = WIDTH'(sum[SLICE-1] ^ ov);
      else                       final_d = result_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= src_a;
                  b_q        <= src_b;
                  op_q       <= alu_control;
                  carry_q    <= (alu_control == OP_SUB) || (alu_control == OP_SLT);
                  cnt_q      <= '0;
                  result_q   <= '0;
                  zero_q     <= 1'b0;
                  illegal_q  <= 1'b0;
                  in_ready_q <= 1'b0;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               cnt_q   <= cnt_q + 1'b1;
               carry_q <= sum[SLICE];
               if (last) begin
                  result_q    <= final_d;
                  zero_q      <= (final_d == '0);
                  illegal_q   <= !legal;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  result_q <= result_d;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule
